// File: rtl/game_bus_if.sv
`default_nettype none
// ============================================================================
// Module      : game_bus_if
// Description : Memory-mapped bus between the game bus master and the
//               extras region (timer, strike counter).
//               addr/data/we/en : master -> responder, registered by master
//               q               : responder -> master, valid the cycle after
//                                 a read is issued
// Revision    : 1.0 - initial release
// ============================================================================
interface game_bus_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data;
  logic                  we;
  logic                  en;
  logic [DATA_WIDTH-1:0] q;

  modport master (output addr, output data, output we, output en, input q);
  modport slave  (input addr, input data, input we, input en, output q);
endinterface
`default_nettype wire

// File: rtl/game_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : game_bus_master
// Description : Bus initiator for the extras region. Loads the countdown
//               timer and clears the strike register on start, then polls the
//               timer and writes every new strike count. Reports game end.
// Ports       : clk        - system clock
//               reset_n    - asynchronous active-low reset
//               start      - one-cycle pulse, begin (or restart) a game
//               start_sec  - initial seconds, sampled on start
//               strike_in  - one-cycle strike pulse from puzzle modules
//               bus        - master side of game_bus_if (addr/data/we/en/q)
//               time_left  - last seconds value read from the timer
//               strikes    - current strike count
//               busy       - state is not IDLE
//               game_over  - game has ended
//               exploded   - game lost (timeout or max strikes)
// Revision    : 1.0 - initial release
// ============================================================================
module game_bus_master #(
  parameter int          DATA_WIDTH  = 16,
  parameter int          ADDR_WIDTH  = 16,
  parameter int unsigned TIMER_ADDR  = 32'h0000_F330,
  parameter int unsigned STRIKE_ADDR = 32'h0000_F663,
  parameter int unsigned POLL_CYCLES = 50000,
  parameter int unsigned MAX_STRIKES = 3
) (
  input  wire logic                  clk,
  input  wire logic                  reset_n,
  input  wire logic                  start,
  input  wire logic [DATA_WIDTH-1:0] start_sec,
  input  wire logic                  strike_in,
  game_bus_if.master                 bus,
  output logic      [DATA_WIDTH-1:0] time_left,
  output logic      [2:0]            strikes,
  output logic                       busy,
  output logic                       game_over,
  output logic                       exploded
);

  localparam int                    CNT_W     = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [CNT_W-1:0]      POLL_LAST = CNT_W'(POLL_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] T_ADDR    = ADDR_WIDTH'(TIMER_ADDR);
  localparam logic [ADDR_WIDTH-1:0] S_ADDR    = ADDR_WIDTH'(STRIKE_ADDR);
  localparam logic [2:0]            MAX_S     = 3'(MAX_STRIKES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_T = 3'd1,
    S_CLR_S  = 3'd2,
    S_WAIT   = 3'd3,
    S_RD_REQ = 3'd4,
    S_RD_CAP = 3'd5,
    S_WR_S   = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    we_q;
  logic                    en_q;
  logic [DATA_WIDTH-1:0]   start_sec_q;
  logic [DATA_WIDTH-1:0]   time_left_q;
  logic [2:0]              strikes_q;
  logic [1:0]              pending_q;
  logic [1:0]              pending_d;
  logic [CNT_W-1:0]        poll_cnt_q;
  logic                    busy_q;
  logic                    game_over_q;
  logic                    exploded_q;

  logic                    strike_active;
  logic                    pending_dec;
  logic [2:0]              strikes_inc;

  // Strikes are only counted while a game is in progress.
  assign strike_active = (state_q != S_IDLE) && (state_q != S_DONE);
  // One pending strike is consumed on the cycle that leaves WR_S.
  assign pending_dec   = (state_q == S_WR_S);
  assign strikes_inc   = strikes_q + 3'd1;

  // Saturating pending counter; a strike arriving on a consume cycle cancels out.
  always_comb begin
    pending_d = pending_q;
    if (strike_active && strike_in && !pending_dec) begin
      if (pending_q != 2'd3) begin
        pending_d = pending_q + 2'd1;
      end
    end else if (pending_dec && !(strike_active && strike_in)) begin
      if (pending_q != 2'd0) begin
        pending_d = pending_q - 2'd1;
      end
    end
  end

  // Bus outputs are loaded on entry to a bus state so each transaction
  // occupies exactly the cycle the FSM spends in that state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      we_q        <= 1'b0;
      en_q        <= 1'b0;
      start_sec_q <= '0;
      time_left_q <= '0;
      strikes_q   <= 3'd0;
      pending_q   <= 2'd0;
      poll_cnt_q  <= '0;
      busy_q      <= 1'b0;
      game_over_q <= 1'b0;
      exploded_q  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      addr_q    <= '0;
      data_q    <= '0;
      we_q      <= 1'b0;
      en_q      <= 1'b0;

      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            start_sec_q <= start_sec;
            strikes_q   <= 3'd0;
            pending_q   <= 2'd0;
            poll_cnt_q  <= '0;
            game_over_q <= 1'b0;
            exploded_q  <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= S_LOAD_T;
            addr_q      <= T_ADDR;
            data_q      <= start_sec;
            we_q        <= 1'b1;
            en_q        <= 1'b1;
          end
        end

        S_LOAD_T: begin
          time_left_q <= start_sec_q;
          state_q     <= S_CLR_S;
          addr_q      <= S_ADDR;
          data_q      <= '0;
          we_q        <= 1'b1;
          en_q        <= 1'b1;
        end

        S_CLR_S: begin
          poll_cnt_q <= '0;
          state_q    <= S_WAIT;
        end

        S_WAIT: begin
          if (pending_q != 2'd0) begin
            // Counter is held so a poll that was due fires right after the write.
            state_q <= S_WR_S;
            addr_q  <= S_ADDR;
            data_q  <= DATA_WIDTH'(strikes_inc);
            we_q    <= 1'b1;
            en_q    <= 1'b1;
          end else if (poll_cnt_q == POLL_LAST) begin
            poll_cnt_q <= '0;
            state_q    <= S_RD_REQ;
            addr_q     <= T_ADDR;
            en_q       <= 1'b1;
          end else begin
            poll_cnt_q <= poll_cnt_q + 1'b1;
          end
        end

        S_RD_REQ: begin
          state_q <= S_RD_CAP;
        end

        S_RD_CAP: begin
          time_left_q <= bus.q;
          if (bus.q == '0) begin
            game_over_q <= 1'b1;
            exploded_q  <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            state_q <= S_WAIT;
          end
        end

        S_WR_S: begin
          strikes_q <= strikes_inc;
          if (strikes_inc >= MAX_S) begin
            game_over_q <= 1'b1;
            exploded_q  <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            state_q <= S_WAIT;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.addr  = addr_q;
  assign bus.data  = data_q;
  assign bus.we    = we_q;
  assign bus.en    = en_q;
  assign time_left = time_left_q;
  assign strikes   = strikes_q;
  assign busy      = busy_q;
  assign game_over = game_over_q;
  assign exploded  = exploded_q;

endmodule
`default_nettype wire
